// File: rtl/lzs_stream_check.sv
// lzs_stream_check: checks an LZS encoder output stream byte-by-byte against an expected stream.
// Words from the DUT are buffered in a FIFO and then compared lane by lane, MSB lane first.
// The checker counts compared bytes and mismatching bytes, records the first mismatch,
// and reports pass/fail at the end of the stream.
// Ports: clk, rst (async, active-high), clr (sync restart)
//        dut_data/dut_valid/dut_last : encoder words, no backpressure
//        exp_data/exp_valid/exp_eof/exp_ready : expected-word source handshake
//        busy, done, pass, ovf, len_err, halt : status
//        byte_cnt, err_cnt, err_pos, err_got, err_exp : counters and first-mismatch capture
// Option: define LZS_CHK_STOP_EN to move to FAIL and assert halt on the first mismatch.
module lzs_stream_check #(
  parameter int DW      = 16,
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DW-1:0]    dut_data,
  input  logic             dut_valid,
  input  logic             dut_last,
  input  logic [DW-1:0]    exp_data,
  input  logic             exp_valid,
  input  logic             exp_eof,
  output logic             exp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             ovf,
  output logic             len_err,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] err_pos,
  output logic [7:0]       err_got,
  output logic [7:0]       err_exp,
  output logic             halt
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [DW:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] cnt;
  logic push_req, push, pop, full, nonempty, last_h, stop, set_len, first, ovf_n, len_n;
  logic [DW-1:0] head;
  logic [NB-1:0] mm;
  logic [CNT_W-1:0] pc, lane, byte_n, err_n, pos_n;
  logic [CNT_W:0] err_sum;
  logic [7:0] got_b, exp_b, got_n, exp_n;
  assign nonempty  = cnt != '0;
  assign full      = cnt == (FIFO_AW+1)'(DEPTH);
  assign {last_h, head} = mem[rp];
  assign exp_ready = state == RUN && nonempty && exp_valid;
  assign pop       = exp_ready;
  assign push_req  = dut_valid && (state == IDLE || state == RUN) && !clr;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push      = push_req && (!full || pop);
  assign busy      = state == RUN;
  assign done      = state == DONE || state == FAIL;
`ifdef LZS_CHK_STOP_EN
  assign stop = pop && mm != '0;
  assign halt = state == FAIL;
`else
  assign stop = 1'b0;
  assign halt = 1'b0;
`endif
  // Scan lanes from highest index down so the lowest mismatching lane is the one captured.
  always_comb begin
    mm    = '0;
    pc    = '0;
    lane  = '0;
    got_b = '0;
    exp_b = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      mm[i] = head[DW-1-8*i -: 8] != exp_data[DW-1-8*i -: 8];
      pc    = pc + CNT_W'(mm[i]);
      if (mm[i]) begin
        lane  = CNT_W'(i);
        got_b = head[DW-1-8*i -: 8];
        exp_b = exp_data[DW-1-8*i -: 8];
      end
    end
  end
  always_comb begin
    err_sum = {1'b0, err_cnt} + {1'b0, pc};
    first   = pop && mm != '0 && err_cnt == '0;
    byte_n  = pop ? byte_cnt + CNT_W'(NB) : byte_cnt;
    err_n   = !pop ? err_cnt : err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    pos_n   = first ? byte_cnt + lane : err_pos;
    got_n   = first ? got_b : err_got;
    exp_n   = first ? exp_b : err_exp;
    // Short expected stream while RUN, or extra expected words once DONE.
    set_len = (state == RUN && exp_eof && !exp_valid && nonempty) || (state == DONE && exp_valid);
    len_n   = len_err || set_len;
    ovf_n   = ovf || (push_req && full && !pop);
    state_n = state == IDLE && push_req ? RUN
            : state == RUN && stop ? FAIL
            : state == RUN && ((pop && last_h) || set_len) ? DONE
            : state;
  end
  always_ff @(posedge clk) if (push) mem[wp] <= {dut_last, dut_data};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; wp <= '0; rp <= '0; cnt <= '0;
      byte_cnt <= '0; err_cnt <= '0; err_pos <= '0; err_got <= '0; err_exp <= '0;
      ovf <= 1'b0; len_err <= 1'b0; pass <= 1'b0;
    end else if (clr) begin
      state <= IDLE; wp <= '0; rp <= '0; cnt <= '0;
      byte_cnt <= '0; err_cnt <= '0; err_pos <= '0; err_got <= '0; err_exp <= '0;
      ovf <= 1'b0; len_err <= 1'b0; pass <= 1'b0;
    end else begin
      state    <= state_n;
      wp       <= wp + FIFO_AW'(push);
      rp       <= rp + FIFO_AW'(pop);
      cnt      <= cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      byte_cnt <= byte_n;
      err_cnt  <= err_n;
      err_pos  <= pos_n;
      err_got  <= got_n;
      err_exp  <= exp_n;
      ovf      <= ovf_n;
      len_err  <= len_n;
      pass     <= (state_n == DONE || state_n == FAIL) && err_n == '0 && !ovf_n && !len_n;
    end
  end
endmodule

// File: tb/tb_lzs_stream_check.sv
// tb_lzs_stream_check: randomized self-checking bench for lzs_stream_check (DW=16, FIFO_AW=2).
module tb_lzs_stream_check;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, clr, dut_valid, dut_last, exp_valid, exp_eof, exp_ready;
  logic busy, done, pass, ovf, len_err, halt;
  logic [15:0] dut_data, exp_data;
  logic [31:0] byte_cnt, err_cnt, err_pos;
  logic [7:0] err_got, err_exp;
  int total = 0, bad = 0;
  logic [15:0] dw [16], ew [16];
  int m_err, m_pos;
  logic [7:0] m_got, m_exp;
`ifdef LZS_CHK_STOP_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  lzs_stream_check #(.DW(16), .FIFO_AW(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .dut_data(dut_data), .dut_valid(dut_valid),
    .dut_last(dut_last), .exp_data(exp_data), .exp_valid(exp_valid), .exp_eof(exp_eof),
    .exp_ready(exp_ready), .busy(busy), .done(done), .pass(pass), .ovf(ovf),
    .len_err(len_err), .byte_cnt(byte_cnt), .err_cnt(err_cnt), .err_pos(err_pos),
    .err_got(err_got), .err_exp(err_exp), .halt(halt)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    dut_valid = 0; dut_last = 0; dut_data = 0;
    exp_valid = 0; exp_eof = 0; exp_data = 0;
  endtask
  task automatic do_clr();
    clr = 1;
    cyc();
    clr = 0;
  endtask
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      dut_valid = 1; dut_data = dw[i]; dut_last = (i == n - 1);
      cyc();
    end
    dut_valid = 0; dut_last = 0;
  endtask
  // Reference: flatten both streams into bytes, MSB byte first, and compare.
  task automatic model(input int n);
    logic [7:0] g, e;
    m_err = 0; m_pos = 0; m_got = 0; m_exp = 0;
    for (int k = 0; k < n; k++)
      for (int l = 0; l < 2; l++) begin
        g = dw[k][15-8*l -: 8];
        e = ew[k][15-8*l -: 8];
        if (g != e) begin
          if (m_err == 0) begin m_pos = 2 * k + l; m_got = g; m_exp = e; end
          m_err++;
        end
      end
  endtask
  // Drives n DUT words and the expected stream at random rates (pv/pe percent per cycle).
  // The occupancy model keeps at most 3 words outstanding so the FIFO never overflows.
  task automatic run_stream(input int n, input int pv, input int pe, input string tag);
    int i, k, occ;
    bit run, pu, po;
    i = 0; k = 0; occ = 0; run = 0;
    for (int c = 0; c < 400 && k < n; c++) begin
      pu = i < n && $urandom_range(99) < pv;
      dut_valid = pu; dut_data = pu ? dw[i] : 16'($urandom); dut_last = pu && i == n - 1;
      exp_valid = occ >= 3 || $urandom_range(99) < pe;
      exp_data = ew[k];
      po = run && occ > 0 && exp_valid;
      @(negedge clk);
      total++;
      if (exp_ready !== po) begin
        bad++;
        $display("FAIL %s exp_ready cycle %0d: got %b want %b", tag, c, exp_ready, po);
      end
      cyc();
      if (pu) begin run = 1; i++; end
      occ += int'(pu) - int'(po);
      if (po) k++;
    end
    quiet();
    total++;
    if (k != n) begin bad++; $display("FAIL %s timeout: consumed %0d want %0d", tag, k, n); end
  endtask
  task automatic test_reset();
    rst = 1; clr = 0; quiet();
    dut_valid = 1; exp_valid = 1;
    #3;
    total++;
    if ({busy, done, pass, ovf, len_err, halt, exp_ready} !== 7'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0", {busy, done, pass, ovf, len_err, halt, exp_ready});
    end
    total++;
    if ({byte_cnt, err_cnt, err_pos, err_got, err_exp} !== 112'b0) begin
      bad++; $display("FAIL reset_cnts: got %0h/%0h/%0h want 0", byte_cnt, err_cnt, err_pos);
    end
    quiet();
    cyc();
    rst = 0;
  endtask
  task automatic test_match();
    do_clr();
    dw[0] = 16'h1234; dw[1] = 16'h5678; ew[0] = 16'h1234; ew[1] = 16'h5678;
    run_stream(2, 100, 100, "match");
    total++;
    if (byte_cnt !== 4 || err_cnt !== 0) begin
      bad++; $display("FAIL match_cnt: got %0d/%0d want 4/0", byte_cnt, err_cnt);
    end
    total++;
    if ({done, pass, busy, halt} !== 4'b1100) begin
      bad++; $display("FAIL match_flags: got %b want 1100", {done, pass, busy, halt});
    end
  endtask
  task automatic test_mismatch();
    do_clr();
    dw[0] = 16'h1234; dw[1] = 16'h56FF; ew[0] = 16'h1234; ew[1] = 16'h5678;
    run_stream(2, 100, 100, "mismatch");
    total++;
    if (err_cnt !== 1 || err_pos !== 3) begin
      bad++; $display("FAIL mism_cnt: got %0d/%0d want 1/3", err_cnt, err_pos);
    end
    total++;
    if (err_got !== 8'hFF || err_exp !== 8'h78) begin
      bad++; $display("FAIL mism_bytes: got %h/%h want ff/78", err_got, err_exp);
    end
    total++;
    if ({done, pass, halt} !== {2'b10, STOP}) begin
      bad++; $display("FAIL mism_flags: got %b want %b", {done, pass, halt}, {2'b10, STOP});
    end
  endtask
  task automatic test_overflow();
    do_clr();
    for (int i = 0; i < 5; i++) begin
      dw[i] = 16'($urandom); ew[i] = dw[i];
      dut_valid = 1; dut_data = dw[i]; dut_last = (i == 3);
      cyc();
    end
    quiet();
    total++;
    if (ovf !== 1 || busy !== 1) begin
      bad++; $display("FAIL ovf_set: got ovf=%b busy=%b want 1/1", ovf, busy);
    end
    exp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      exp_data = ew[k];
      @(negedge clk);
      total++;
      if (exp_ready !== 1) begin bad++; $display("FAIL ovf_ready %0d: got %b want 1", k, exp_ready); end
      cyc();
    end
    quiet();
    total++;
    if ({done, pass, ovf} !== 3'b101 || byte_cnt !== 8 || err_cnt !== 0) begin
      bad++; $display("FAIL ovf_end: got %b cnt=%0d err=%0d want 101/8/0", {done, pass, ovf}, byte_cnt, err_cnt);
    end
  endtask
  task automatic test_len_short();
    do_clr();
    dw[0] = 16'($urandom); dw[1] = 16'($urandom);
    push_words(2);
    exp_valid = 1; exp_data = dw[0];
    @(negedge clk);
    total++;
    if (exp_ready !== 1) begin bad++; $display("FAIL short_ready: got %b want 1", exp_ready); end
    cyc();
    exp_valid = 0; exp_eof = 1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b10) begin bad++; $display("FAIL short_run: got %b want 10", {busy, done}); end
    cyc();
    quiet();
    total++;
    if ({done, len_err, pass} !== 3'b110 || byte_cnt !== 2) begin
      bad++; $display("FAIL short_end: got %b cnt=%0d want 110/2", {done, len_err, pass}, byte_cnt);
    end
  endtask
  task automatic test_len_long();
    do_clr();
    dw[0] = 16'($urandom);
    push_words(1);
    exp_valid = 1; exp_data = dw[0];
    cyc();
    exp_valid = 0;
    total++;
    if ({done, pass, len_err} !== 3'b110) begin
      bad++; $display("FAIL long_done: got %b want 110", {done, pass, len_err});
    end
    exp_valid = 1; exp_data = 16'($urandom); dut_valid = 1; dut_last = 1; dut_data = 16'($urandom);
    @(negedge clk);
    total++;
    if (exp_ready !== 0) begin bad++; $display("FAIL long_ready: got %b want 0", exp_ready); end
    cyc();
    quiet();
    total++;
    if ({done, pass, len_err} !== 3'b101 || byte_cnt !== 2) begin
      bad++; $display("FAIL long_end: got %b cnt=%0d want 101/2", {done, pass, len_err}, byte_cnt);
    end
  endtask
  task automatic test_clr_push();
    do_clr();
    clr = 1; dut_valid = 1; dut_last = 1; dut_data = 16'h1234;
    cyc();
    clr = 0; dut_valid = 0; dut_last = 0; exp_valid = 1; exp_data = 16'h1234;
    @(negedge clk);
    total++;
    if ({exp_ready, busy, done} !== 3'b000 || byte_cnt !== 0) begin
      bad++; $display("FAIL clr_push: got %b cnt=%0d want 000/0", {exp_ready, busy, done}, byte_cnt);
    end
    cyc();
    quiet();
    total++;
    if (byte_cnt !== 0 || busy !== 0) begin
      bad++; $display("FAIL clr_after: got cnt=%0d busy=%b want 0/0", byte_cnt, busy);
    end
  endtask
  task automatic test_async_reset();
    do_clr();
    dw[0] = 16'($urandom); dw[1] = 16'($urandom);
    dut_valid = 1; dut_data = dw[0]; cyc();
    dut_data = dw[1]; exp_valid = 1; exp_data = dw[0]; cyc();
    quiet();
    total++;
    if (byte_cnt !== 2 || busy !== 1) begin
      bad++; $display("FAIL arst_pre: got cnt=%0d busy=%b want 2/1", byte_cnt, busy);
    end
    #2 rst = 1;
    #1;
    total++;
    if (byte_cnt !== 0 || busy !== 0) begin
      bad++; $display("FAIL arst_now: got cnt=%0d busy=%b want 0/0", byte_cnt, busy);
    end
    cyc();
    rst = 0;
    exp_valid = 1;
    @(negedge clk);
    total++;
    if (exp_ready !== 0) begin bad++; $display("FAIL arst_fifo: got %b want 0", exp_ready); end
    cyc();
    quiet();
  endtask
`ifdef LZS_CHK_STOP_EN
  task automatic test_stop();
    do_clr();
    dw[0] = 16'h1234; dw[1] = 16'h5678;
    push_words(2);
    exp_valid = 1; exp_data = 16'h1235;
    cyc();
    exp_data = 16'h5678;
    @(negedge clk);
    total++;
    if ({halt, exp_ready, busy, done} !== 4'b1001) begin
      bad++; $display("FAIL stop_flags: got %b want 1001", {halt, exp_ready, busy, done});
    end
    total++;
    if (byte_cnt !== 2 || err_cnt !== 1 || err_pos !== 1 || err_got !== 8'h34 || err_exp !== 8'h35) begin
      bad++; $display("FAIL stop_cap: got %0d/%0d/%0d %h/%h want 2/1/1 34/35", byte_cnt, err_cnt, err_pos, err_got, err_exp);
    end
    cyc();
    total++;
    if (byte_cnt !== 2 || halt !== 1) begin
      bad++; $display("FAIL stop_freeze: got cnt=%0d halt=%b want 2/1", byte_cnt, halt);
    end
    quiet();
    do_clr();
    total++;
    if ({busy, done, pass, ovf, len_err, halt, exp_ready, byte_cnt, err_cnt} !== 71'b0) begin
      bad++; $display("FAIL stop_clr: got %b want 0", {busy, done, pass, ovf, len_err, halt, exp_ready});
    end
  endtask
`endif
  task automatic test_random();
    int n;
    for (int t = 0; t < 25; t++) begin
      do_clr();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        dw[k] = 16'($urandom);
        ew[k] = dw[k];
        if (!STOP && $urandom_range(5) == 0) ew[k][15:8] = ew[k][15:8] ^ 8'($urandom_range(1, 255));
        if (!STOP && $urandom_range(5) == 0) ew[k][7:0] = ew[k][7:0] ^ 8'($urandom_range(1, 255));
      end
      model(n);
      run_stream(n, $urandom_range(30, 100), $urandom_range(30, 100), "random");
      total++;
      if (byte_cnt !== 32'(2 * n) || err_cnt !== 32'(m_err)) begin
        bad++; $display("FAIL rand_cnt %0d: got %0d/%0d want %0d/%0d", t, byte_cnt, err_cnt, 2 * n, m_err);
      end
      total++;
      if (err_pos !== 32'(m_pos) || err_got !== m_got || err_exp !== m_exp) begin
        bad++; $display("FAIL rand_first %0d: got %0d %h/%h want %0d %h/%h", t, err_pos, err_got, err_exp, m_pos, m_got, m_exp);
      end
      total++;
      if ({done, pass} !== {1'b1, m_err == 0}) begin
        bad++; $display("FAIL rand_flags %0d: got %b want %b", t, {done, pass}, {1'b1, m_err == 0});
      end
    end
  endtask
  task automatic test_back_to_back();
    do_clr();
    for (int k = 0; k < 8; k++) begin dw[k] = 16'($urandom); ew[k] = dw[k]; end
    run_stream(8, 100, 100, "b2b");
    total++;
    if (byte_cnt !== 16 || {done, pass, ovf} !== 3'b110) begin
      bad++; $display("FAIL b2b_end: got cnt=%0d %b want 16/110", byte_cnt, {done, pass, ovf});
    end
  endtask
  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_overflow();
    test_len_short();
    test_len_long();
    test_clr_push();
    test_async_reset();
`ifdef LZS_CHK_STOP_EN
    test_stop();
`endif
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
